// File: rtl/cis_scan_sequencer.sv
// cis_scan_sequencer: job scheduler in front of cis_controller.
// Define CIS_SEQ_WDOG_EN to add the RUN-state no-toggle watchdog.
module cis_scan_sequencer #(
   parameter int unsigned ARM_CYCLES = 16,
   parameter logic [23:0] TRIG_MIN   = 24'd5376
`ifdef CIS_SEQ_WDOG_EN
   ,
   parameter logic [23:0] WDOG_CYCLES = 24'd1000000
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_lines,
   input  logic [1:0]  cmd_mode,
   input  logic        cmd_abort,
   input  logic [23:0] trig_period,
   input  logic        si_toggle,
   input  logic [1:0]  si_cnt,
   output logic        cis_rst,
   output logic [1:0]  cis_mode,
   output logic        ext_start,
   output logic        line_done,
   output logic [15:0] line_idx,
   output logic        busy,
   output logic        done,
   output logic        aborted
);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      RUN
   } state_t;

   localparam int AW = $clog2(ARM_CYCLES + 1);
   localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);

   state_t state, next;

   logic [AW-1:0] arm_cnt;
   logic [15:0]   lines_q;
   logic [23:0]   period_q;
   logic [23:0]   trig_tmr;
   logic [15:0]   trig_cnt;
   logic [15:0]   done_cnt;
   logic          saw_blue;
   logic          tog_s1, tog_s2, tog_s3;
   logic [1:0]    cnt_s1, cnt_s2;

   logic colour_start;
   logic line_ev;
   logic last;
   logic wdog_hit;
   logic accept;
   logic finish;
   logic kill_job;
   logic line_set;
   logic fire;

   assign colour_start = tog_s2 ^ tog_s3;
   assign line_ev = (state == RUN) && colour_start
                    && (cnt_s2 == 2'd0) && saw_blue;
   assign last = (done_cnt == lines_q - 16'd1);

`ifdef CIS_SEQ_WDOG_EN
   logic [23:0] wd_cnt;

   assign wdog_hit = (state == RUN) && !colour_start
                     && (wd_cnt == WDOG_CYCLES - 24'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (state != RUN || colour_start) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 24'd1;
      end
   end
`else
   assign wdog_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next     = state;
      accept   = 1'b0;
      finish   = 1'b0;
      kill_job = 1'b0;
      line_set = 1'b0;
      fire     = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept = 1'b1;
               next   = ARM;
            end
         end
         ARM: begin
            if (cmd_abort) begin
               kill_job = 1'b1;
               next     = IDLE;
            end else if (arm_cnt == ARM_LAST) begin
               next = RUN;
               fire = (cis_mode == 2'd2);
            end
         end
         RUN: begin
            // a final line beats a coincident abort
            if (line_ev && last) begin
               line_set = 1'b1;
               finish   = 1'b1;
               next     = IDLE;
            end else if (cmd_abort || wdog_hit) begin
               kill_job = 1'b1;
               next     = IDLE;
            end else begin
               line_set = line_ev;
               fire     = (cis_mode == 2'd2)
                          && (trig_tmr == period_q - 24'd1)
                          && (trig_cnt != lines_q);
            end
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lines_q  <= '0;
         period_q <= '0;
         cis_mode <= '0;
      end else if (accept) begin
         lines_q  <= (cmd_lines == 16'd0) ? 16'd1 : cmd_lines;
         cis_mode <= (cmd_mode == 2'd3) ? 2'd0 : cmd_mode;
         period_q <= (trig_period < TRIG_MIN) ? TRIG_MIN
                                              : trig_period;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm_cnt <= '0;
      end else if (accept) begin
         arm_cnt <= '0;
      end else if (state == ARM) begin
         arm_cnt <= arm_cnt + 1'b1;
      end
   end

   // trigger count caps at lines: pulses issued, not lines done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_tmr <= '0;
         trig_cnt <= '0;
      end else if (accept) begin
         trig_tmr <= '0;
         trig_cnt <= '0;
      end else if (fire) begin
         trig_tmr <= '0;
         trig_cnt <= trig_cnt + 16'd1;
      end else if (state == RUN && cis_mode == 2'd2
                   && trig_cnt != lines_q) begin
         trig_tmr <= trig_tmr + 24'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tog_s1 <= 1'b0;
         tog_s2 <= 1'b0;
         tog_s3 <= 1'b0;
         cnt_s1 <= '0;
         cnt_s2 <= '0;
      end else begin
         tog_s1 <= si_toggle;
         tog_s2 <= tog_s1;
         tog_s3 <= tog_s2;
         cnt_s1 <= si_cnt;
         cnt_s2 <= cnt_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         saw_blue <= 1'b0;
      end else if (accept) begin
         saw_blue <= 1'b0;
      end else if (state == RUN && colour_start) begin
         saw_blue <= (cnt_s2 == 2'd2);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_cnt <= '0;
         line_idx <= '0;
      end else if (accept) begin
         done_cnt <= '0;
      end else if (line_set) begin
         line_idx <= done_cnt;
         done_cnt <= done_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_done <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         ext_start <= 1'b0;
      end else begin
         line_done <= line_set;
         done      <= finish;
         aborted   <= kill_job;
         ext_start <= fire;
      end
   end

   assign cmd_ready = (state == IDLE);
   assign cis_rst   = (state == IDLE);
   assign busy      = (state != IDLE);

endmodule
